dispensador_billetes: RTL and testbench

Sequencer for the cash-dispense mechanism behind the ATM controller. On an `entregar_dinero` strobe it latches the requested `monto`. It plans a greedy decomposition into banknotes, limited by the on-board inventory. It then emits one bill-eject pulse per cycle, largest denomination first, and updates inventory. An amount that cannot be dispensed exactly is rejected atomically: no bills are ejected and inventory is unchanged.

---
 rtl/dispensador_billetes.sv | 199 +++++++++++++++++++
 tb/tb_dispensador_billetes.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dispensador_billetes.sv
// Cash-dispense sequencer: greedy banknote plan against on-board inventory, then one eject per cycle.
// Optional macro DISPENSADOR_TOTAL_EN adds the total_entregado running-sum output.
module dispensador_billetes #(
   parameter int unsigned INV_INICIAL = 100,
   parameter int unsigned ANCHO_INV   = 8,
   parameter int unsigned UMBRAL_BAJO = 10,
   parameter int unsigned MONTO_MAX   = 200000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        entregar_dinero,
   input  logic [31:0] monto,
   input  logic        recargar,
   output logic        billete_stb,
   output logic [2:0]  denominacion,
   output logic        ocupado,
   output logic        listo,
   output logic        error_dispensar,
   output logic [4:0]  inventario_bajo
`ifdef DISPENSADOR_TOTAL_EN
   ,
   output logic [31:0] total_entregado
`endif
);

   localparam int unsigned NumDen = 5;
   localparam logic [ANCHO_INV-1:0] InvIni = ANCHO_INV'(INV_INICIAL);
   localparam logic [ANCHO_INV-1:0] Uno    = {{(ANCHO_INV-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      StIdle,
      StPlanificar,
      StEntregar,
      StFin,
      StError
   } estado_e;

   function automatic logic [31:0] val_de(input logic [2:0] k);
      logic [31:0] v;
      case (k)
         3'd0:    v = 32'd20000;
         3'd1:    v = 32'd10000;
         3'd2:    v = 32'd5000;
         3'd3:    v = 32'd2000;
         default: v = 32'd1000;
      endcase
      return v;
   endfunction

   estado_e              estado_q;
   logic [31:0]          resto_q;
   logic [2:0]           k_q;
   logic [ANCHO_INV-1:0] inv_q  [NumDen];
   logic [ANCHO_INV-1:0] tmp_q  [NumDen];
   logic [ANCHO_INV-1:0] plan_q [NumDen];

   logic                 billete_stb_q;
   logic [2:0]           denominacion_q;
   logic                 ocupado_q;
   logic                 listo_q;
   logic                 error_q;
   logic [4:0]           bajo_q;
`ifdef DISPENSADOR_TOTAL_EN
   logic [31:0]          total_q;
`endif

   logic [2:0]           sel;
   logic                 hay_plan;
   logic                 otros;
   logic                 ultimo;
   logic [31:0]          val_k;

   // Lowest pending denomination index, i.e. largest bill first.
   always_comb begin
      sel      = 3'd0;
      hay_plan = 1'b0;
      for (int i = NumDen - 1; i >= 0; i--) begin
         if (plan_q[i] != '0) begin
            sel      = 3'(i);
            hay_plan = 1'b1;
         end
      end
   end

   always_comb begin
      otros = 1'b0;
      for (int i = 0; i < NumDen; i++) begin
         if ((3'(i) != sel) && (plan_q[i] != '0)) otros = 1'b1;
      end
   end

   assign ultimo = (plan_q[sel] == Uno) && !otros;
   assign val_k  = val_de(k_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         estado_q       <= StIdle;
         resto_q        <= '0;
         k_q            <= '0;
         billete_stb_q  <= 1'b0;
         denominacion_q <= '0;
         ocupado_q      <= 1'b0;
         listo_q        <= 1'b0;
         error_q        <= 1'b0;
         bajo_q         <= '0;
`ifdef DISPENSADOR_TOTAL_EN
         total_q        <= '0;
`endif
         for (int i = 0; i < NumDen; i++) begin
            inv_q[i]  <= InvIni;
            tmp_q[i]  <= '0;
            plan_q[i] <= '0;
         end
      end else begin
         billete_stb_q  <= 1'b0;
         denominacion_q <= '0;
         listo_q        <= 1'b0;
         error_q        <= 1'b0;
         for (int i = 0; i < NumDen; i++) begin
            bajo_q[i] <= (32'(inv_q[i]) < UMBRAL_BAJO);
         end

         case (estado_q)
            StIdle: begin
               if (entregar_dinero) begin
                  ocupado_q <= 1'b1;
                  if (monto > MONTO_MAX) begin
                     estado_q <= StError;
                  end else begin
                     resto_q  <= monto;
                     k_q      <= '0;
                     estado_q <= StPlanificar;
                     for (int i = 0; i < NumDen; i++) begin
                        plan_q[i] <= '0;
                        tmp_q[i]  <= inv_q[i];
                     end
                  end
               end else if (recargar) begin
                  for (int i = 0; i < NumDen; i++) inv_q[i] <= InvIni;
               end
            end

            // Plan against a scratch copy so a rejected amount never touches inventory.
            StPlanificar: begin
               if (k_q == 3'd5) begin
                  if (resto_q != '0)  estado_q <= StError;
                  else if (hay_plan)  estado_q <= StEntregar;
                  else                estado_q <= StFin;
               end else if ((resto_q >= val_k) && (tmp_q[k_q] != '0)) begin
                  resto_q       <= resto_q - val_k;
                  tmp_q[k_q]    <= tmp_q[k_q] - Uno;
                  plan_q[k_q]   <= plan_q[k_q] + Uno;
               end else begin
                  k_q <= k_q + 3'd1;
               end
            end

            StEntregar: begin
               billete_stb_q  <= 1'b1;
               denominacion_q <= sel;
               plan_q[sel]    <= plan_q[sel] - Uno;
               inv_q[sel]     <= inv_q[sel] - Uno;
`ifdef DISPENSADOR_TOTAL_EN
               total_q        <= total_q + val_de(sel);
`endif
               if (ultimo) estado_q <= StFin;
            end

            StFin: begin
               listo_q   <= 1'b1;
               ocupado_q <= 1'b0;
               estado_q  <= StIdle;
            end

            StError: begin
               error_q   <= 1'b1;
               ocupado_q <= 1'b0;
               estado_q  <= StIdle;
            end

            default: begin
               ocupado_q <= 1'b0;
               estado_q  <= StIdle;
            end
         endcase
      end
   end

   assign billete_stb     = billete_stb_q;
   assign denominacion    = denominacion_q;
   assign ocupado         = ocupado_q;
   assign listo           = listo_q;
   assign error_dispensar = error_q;
   assign inventario_bajo = bajo_q;
`ifdef DISPENSADOR_TOTAL_EN
   assign total_entregado = total_q;
`endif

endmodule

// File: tb/tb_dispensador_billetes.sv
// Scoreboard bench for dispensador_billetes: a default instance and one loaded with two bills each.
module tb_dispensador_billetes;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a, ent_a, rec_a, stb_a, ocu_a, listo_a, err_a;
   logic [31:0] monto_a;
   logic [2:0]  den_a;
   logic [4:0]  bajo_a;
   logic        rst_b, ent_b, rec_b, stb_b, ocu_b, listo_b, err_b;
   logic [31:0] monto_b;
   logic [2:0]  den_b;
   logic [4:0]  bajo_b;
`ifdef DISPENSADOR_TOTAL_EN
   logic [31:0] total_a, total_b;
`endif

   dispensador_billetes dut_a (
      .clk             (clk),
      .rst             (rst_a),
      .entregar_dinero (ent_a),
      .monto           (monto_a),
      .recargar        (rec_a),
      .billete_stb     (stb_a),
      .denominacion    (den_a),
      .ocupado         (ocu_a),
      .listo           (listo_a),
      .error_dispensar (err_a),
      .inventario_bajo (bajo_a)
`ifdef DISPENSADOR_TOTAL_EN
      ,
      .total_entregado (total_a)
`endif
   );

   dispensador_billetes #(.INV_INICIAL(2)) dut_b (
      .clk             (clk),
      .rst             (rst_b),
      .entregar_dinero (ent_b),
      .monto           (monto_b),
      .recargar        (rec_b),
      .billete_stb     (stb_b),
      .denominacion    (den_b),
      .ocupado         (ocu_b),
      .listo           (listo_b),
      .error_dispensar (err_b),
      .inventario_bajo (bajo_b)
`ifdef DISPENSADOR_TOTAL_EN
      ,
      .total_entregado (total_b)
`endif
   );

   int          n_chk = 0;
   int          n_fail = 0;
   int          exp_q[$];
   int          obs_q[$];
   int          inv_a[5];
   int          inv_b[5];
   int unsigned tot_a;

   function automatic int val_of(input int code);
      case (code)
         0:       return 20000;
         1:       return 10000;
         2:       return 5000;
         3:       return 2000;
         default: return 1000;
      endcase
   endfunction

   // Expected bill goes into the scoreboard; the inventory/total model follows it.
   task automatic expect_bill(input bit b, input int code);
      exp_q.push_back(code);
      if (b) inv_b[code]--;
      else begin
         inv_a[code]--;
         tot_a += val_of(code);
      end
   endtask

   // Caller raises the strobe at a negedge; this drops it and records output until listo/error.
   task automatic collect(input bit b, input int max_cyc, input int extra_at,
                          input logic [31:0] extra_monto, output bit got_listo,
                          output bit got_err, output int cyc, output int busy,
                          output int first_stb, output int last_stb);
      got_listo = 1'b0; got_err = 1'b0; cyc = 0; busy = 0; first_stb = -1; last_stb = -1;
      for (int c = 1; c <= max_cyc; c++) begin
         @(negedge clk);
         ent_a = 1'b0; ent_b = 1'b0; rec_a = 1'b0; rec_b = 1'b0;
         if (c == extra_at) begin
            if (b) begin ent_b = 1'b1; monto_b = extra_monto; end
            else   begin ent_a = 1'b1; monto_a = extra_monto; end
         end
         cyc = c;
         if (b ? ocu_b : ocu_a) busy++;
         if (b ? stb_b : stb_a) begin
            obs_q.push_back(int'(b ? den_b : den_a));
            if (first_stb < 0) first_stb = c;
            last_stb = c;
         end
         if (b ? listo_b : listo_a) got_listo = 1'b1;
         if (b ? err_b : err_a) got_err = 1'b1;
         if (got_listo || got_err) break;
      end
   endtask

   task automatic test_reset();
      rst_a = 1'b1; rst_b = 1'b1; ent_a = 1'b0; ent_b = 1'b0; rec_a = 1'b0; rec_b = 1'b0;
      monto_a = '0; monto_b = '0;
      repeat (2) @(negedge clk);
      n_chk++;
      if ({stb_a, den_a, ocu_a, listo_a, err_a, bajo_a} !== 12'd0) begin
         n_fail++; $display("FAIL reset_out_a: got %b expected 0",
                            {stb_a, den_a, ocu_a, listo_a, err_a, bajo_a});
      end
      n_chk++;
      if ({stb_b, den_b, ocu_b, listo_b, err_b, bajo_b} !== 12'd0) begin
         n_fail++; $display("FAIL reset_out_b: got %b expected 0",
                            {stb_b, den_b, ocu_b, listo_b, err_b, bajo_b});
      end
`ifdef DISPENSADOR_TOTAL_EN
      n_chk++;
      if (total_a !== 32'd0) begin n_fail++; $display("FAIL reset_total: got %0d expected 0", total_a); end
`endif
      rst_a = 1'b0; rst_b = 1'b0;
      for (int i = 0; i < 5; i++) begin inv_a[i] = 100; inv_b[i] = 2; end
      tot_a = 0;
      for (int i = 0; i < 5; i++) begin
         n_chk++;
         if (int'(dut_a.inv_q[i]) != inv_a[i]) begin
            n_fail++; $display("FAIL reset_inv%0d: got %0d expected %0d", i, dut_a.inv_q[i], inv_a[i]);
         end
      end
      @(negedge clk);
      n_chk++;
      if (bajo_b !== 5'h1f) begin n_fail++; $display("FAIL reset_bajo_b: got %b expected 11111", bajo_b); end
      n_chk++;
      if (bajo_a !== 5'h00) begin n_fail++; $display("FAIL reset_bajo_a: got %b expected 00000", bajo_a); end
   endtask

   task automatic test_dispense_basic();
      bit gl, ge; int cyc, busy, f, l, e, o;
      expect_bill(0, 0); expect_bill(0, 1);
      monto_a = 32'd30000; ent_a = 1'b1;
      collect(0, 60, 0, '0, gl, ge, cyc, busy, f, l);
      n_chk++;
      if (obs_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL basic_count: got %0d bills expected %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() > 0) o = obs_q.pop_front(); else o = -1;
         n_chk++;
         if (o != e) begin n_fail++; $display("FAIL basic_code: got %0d expected %0d", o, e); end
      end
      obs_q.delete();
      n_chk++;
      if (!gl || ge) begin n_fail++; $display("FAIL basic_end: got listo=%0b err=%0b expected 1 0", gl, ge); end
      n_chk++;
      if (l - f != 1) begin n_fail++; $display("FAIL basic_gap: got stb at %0d,%0d expected consecutive", f, l); end
      for (int i = 0; i < 2; i++) begin
         n_chk++;
         if (int'(dut_a.inv_q[i]) != inv_a[i]) begin
            n_fail++; $display("FAIL basic_inv%0d: got %0d expected %0d", i, dut_a.inv_q[i], inv_a[i]);
         end
      end
      n_chk++;
      if (bajo_a !== 5'h00) begin n_fail++; $display("FAIL basic_bajo: got %b expected 00000", bajo_a); end
   endtask

   task automatic test_reject_odd();
      bit gl, ge; int cyc, busy, f, l;
      monto_a = 32'd4520; ent_a = 1'b1;
      collect(0, 60, 0, '0, gl, ge, cyc, busy, f, l);
      n_chk++;
      if (!ge || gl) begin n_fail++; $display("FAIL odd_end: got err=%0b listo=%0b expected 1 0", ge, gl); end
      n_chk++;
      if (obs_q.size() != 0) begin n_fail++; $display("FAIL odd_bills: got %0d expected 0", obs_q.size()); end
      obs_q.delete();
      n_chk++;
      if (ocu_a !== 1'b0) begin n_fail++; $display("FAIL odd_ocupado: got %b expected 0", ocu_a); end
      for (int i = 0; i < 5; i++) begin
         n_chk++;
         if (int'(dut_a.inv_q[i]) != inv_a[i]) begin
            n_fail++; $display("FAIL odd_inv%0d: got %0d expected %0d", i, dut_a.inv_q[i], inv_a[i]);
         end
      end
   endtask

   task automatic test_edge_amounts();
      bit gl, ge; int cyc, busy, f, l, e, o;
      monto_a = 32'd0; ent_a = 1'b1;
      collect(0, 60, 0, '0, gl, ge, cyc, busy, f, l);
      n_chk++;
      if (!gl || cyc != 8 || busy != 7) begin
         n_fail++; $display("FAIL zero_timing: got listo=%0b at %0d busy=%0d expected 1 at 8 busy=7",
                            gl, cyc, busy);
      end
      n_chk++;
      if (obs_q.size() != 0) begin n_fail++; $display("FAIL zero_bills: got %0d expected 0", obs_q.size()); end
      obs_q.delete();
      monto_a = 32'd200001; ent_a = 1'b1;
      collect(0, 60, 0, '0, gl, ge, cyc, busy, f, l);
      n_chk++;
      if (!ge || cyc != 2 || obs_q.size() != 0) begin
         n_fail++; $display("FAIL over_max: got err=%0b at %0d bills=%0d expected 1 at 2 bills=0",
                            ge, cyc, obs_q.size());
      end
      obs_q.delete();
      for (int i = 0; i < 10; i++) expect_bill(0, 0);
      monto_a = 32'd200000; ent_a = 1'b1;
      collect(0, 80, 0, '0, gl, ge, cyc, busy, f, l);
      n_chk++;
      if (!gl || obs_q.size() != 10) begin
         n_fail++; $display("FAIL at_max: got listo=%0b bills=%0d expected 1 10", gl, obs_q.size());
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() > 0) o = obs_q.pop_front(); else o = -1;
         if (o != e) begin n_chk++; n_fail++; $display("FAIL at_max_code: got %0d expected %0d", o, e); end
      end
      obs_q.delete();
      n_chk++;
      if (int'(dut_a.inv_q[0]) != inv_a[0]) begin
         n_fail++; $display("FAIL at_max_inv0: got %0d expected %0d", dut_a.inv_q[0], inv_a[0]);
      end
   endtask

   task automatic test_limited_inventory();
      bit gl, ge; int cyc, busy, f, l, e, o;
      int montos[5]  = '{60000, 7000, 20000, 20000, 20000};
      bit recarga[5] = '{0, 0, 0, 1, 0};
      bit falla[5]   = '{0, 0, 1, 1, 0};
      for (int t = 0; t < 5; t++) begin
         if (t == 4) begin
            rec_b = 1'b1; @(negedge clk); rec_b = 1'b0;
            for (int i = 0; i < 5; i++) inv_b[i] = 2;
         end
         case (t)
            0: begin expect_bill(1, 0); expect_bill(1, 0); expect_bill(1, 1); expect_bill(1, 1); end
            1: begin expect_bill(1, 2); expect_bill(1, 3); end
            4: expect_bill(1, 0);
            default: ;
         endcase
         monto_b = 32'(montos[t]); ent_b = 1'b1; rec_b = recarga[t];
         collect(1, 80, 0, '0, gl, ge, cyc, busy, f, l);
         n_chk++;
         if (ge != falla[t] || gl == falla[t]) begin
            n_fail++; $display("FAIL lim%0d_end: got listo=%0b err=%0b expected err=%0b", t, gl, ge, falla[t]);
         end
         n_chk++;
         if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL lim%0d_count: got %0d expected %0d", t, obs_q.size(), exp_q.size());
         end
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() > 0) o = obs_q.pop_front(); else o = -1;
            n_chk++;
            if (o != e) begin n_fail++; $display("FAIL lim%0d_code: got %0d expected %0d", t, o, e); end
         end
         obs_q.delete();
         for (int i = 0; i < 5; i++) begin
            n_chk++;
            if (int'(dut_b.inv_q[i]) != inv_b[i]) begin
               n_fail++; $display("FAIL lim%0d_inv%0d: got %0d expected %0d", t, i, dut_b.inv_q[i], inv_b[i]);
            end
         end
      end
      n_chk++;
      if (bajo_b !== 5'h1f) begin n_fail++; $display("FAIL lim_bajo: got %b expected 11111", bajo_b); end
   endtask

   task automatic test_reset_mid_dispense();
      bit gl, ge; int cyc, busy, f, l, nstb, e, o;
      for (int i = 0; i < 4; i++) expect_bill(0, 0);
      expect_bill(0, 1);
      monto_a = 32'd90000; ent_a = 1'b1; nstb = 0;
      for (int c = 0; c < 60 && nstb < 2; c++) begin
         @(negedge clk);
         ent_a = 1'b0;
         if (stb_a) begin obs_q.push_back(int'(den_a)); nstb++; end
      end
      n_chk++;
      if (nstb != 2) begin n_fail++; $display("FAIL mid_stb: got %0d pulses expected 2", nstb); end
      for (int i = 0; i < 2; i++) begin
         e = exp_q.pop_front();
         if (obs_q.size() > 0) o = obs_q.pop_front(); else o = -1;
         n_chk++;
         if (o != e) begin n_fail++; $display("FAIL mid_code: got %0d expected %0d", o, e); end
      end
      exp_q.delete(); obs_q.delete();
      rst_a = 1'b1;
      @(negedge clk);
      n_chk++;
      if ({stb_a, den_a, ocu_a, listo_a, err_a, bajo_a} !== 12'd0) begin
         n_fail++; $display("FAIL mid_reset_out: got %b expected 0",
                            {stb_a, den_a, ocu_a, listo_a, err_a, bajo_a});
      end
      rst_a = 1'b0;
      for (int i = 0; i < 5; i++) inv_a[i] = 100;
      tot_a = 0;
      for (int i = 0; i < 5; i++) begin
         n_chk++;
         if (int'(dut_a.inv_q[i]) != inv_a[i]) begin
            n_fail++; $display("FAIL mid_inv%0d: got %0d expected %0d", i, dut_a.inv_q[i], inv_a[i]);
         end
      end
      expect_bill(0, 4);
      monto_a = 32'd1000; ent_a = 1'b1;
      collect(0, 60, 0, '0, gl, ge, cyc, busy, f, l);
      e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = -1;
      n_chk++;
      if (o != e || obs_q.size() != 0 || !gl) begin
         n_fail++; $display("FAIL mid_after: got code %0d extra %0d listo=%0b expected %0d 0 1",
                            o, obs_q.size(), gl, e);
      end
      obs_q.delete();
      n_chk++;
      if (bajo_a !== 5'h00 || int'(dut_a.inv_q[4]) != inv_a[4]) begin
         n_fail++; $display("FAIL mid_inv4: got bajo=%b inv4=%0d expected 00000 %0d",
                            bajo_a, dut_a.inv_q[4], inv_a[4]);
      end
   endtask

   task automatic test_ignored_strobe();
      bit gl, ge; int cyc, busy, f, l, e, o, extra;
      rst_a = 1'b1; @(negedge clk); rst_a = 1'b0;
      for (int i = 0; i < 5; i++) inv_a[i] = 100;
      tot_a = 0;
      expect_bill(0, 0); expect_bill(0, 1);
      monto_a = 32'd30000; ent_a = 1'b1;
      collect(0, 60, 3, 32'd5000, gl, ge, cyc, busy, f, l);
      n_chk++;
      if (obs_q.size() != 2 || !gl || ge) begin
         n_fail++; $display("FAIL busy_strobe: got bills=%0d listo=%0b err=%0b expected 2 1 0",
                            obs_q.size(), gl, ge);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() > 0) o = obs_q.pop_front(); else o = -1;
         n_chk++;
         if (o != e) begin n_fail++; $display("FAIL busy_code: got %0d expected %0d", o, e); end
      end
      obs_q.delete();
      extra = 0;
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         if (stb_a || listo_a || err_a || ocu_a) extra++;
      end
      n_chk++;
      if (extra != 0) begin n_fail++; $display("FAIL busy_queued: got %0d active cycles expected 0", extra); end
`ifdef DISPENSADOR_TOTAL_EN
      n_chk++;
      if (total_a !== tot_a) begin n_fail++; $display("FAIL total: got %0d expected %0d", total_a, tot_a); end
`endif
   endtask

   initial begin
      test_reset();
      test_dispense_basic();
      test_reject_odd();
      test_edge_amounts();
      test_limited_inventory();
      test_reset_mid_dispense();
      test_ignored_strobe();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
